// File: rtl/pll_reset_sequencer.sv
// Staged reset release driven by the PLL lock indication: peripherals leave reset
// first, then the CPU, with lock-loss supervision and a software-requested reset.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES          = 2,
    parameter int LOCK_STABLE_CYCLES   = 4800,
    parameter int PERIPH_TO_CPU_CYCLES = 16,
    parameter int SW_HOLD_CYCLES       = 64,
    parameter int LOSS_CNT_WIDTH       = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      pll_locked,
    input  logic                      sw_reset_req,
    input  logic                      clear_lost,
    output logic                      periph_resetn,
    output logic                      soc_resetn,
    output logic                      ready,
    output logic                      lock_lost,
    output logic [LOSS_CNT_WIDTH-1:0] loss_count
);

    localparam int MAX_A   = (LOCK_STABLE_CYCLES > PERIPH_TO_CPU_CYCLES) ?
                             LOCK_STABLE_CYCLES : PERIPH_TO_CPU_CYCLES;
    localparam int CNT_MAX = (MAX_A > SW_HOLD_CYCLES) ? MAX_A : SW_HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        PERIPH,
        RUN,
        SW_HOLD
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;
    logic                   loss;

    assign locked_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Each terminal compare is against N-1 because the edge that leaves the
    // state is itself one of the N counted edges.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        loss    = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_n = '0;
                if (locked_s) begin
                    state_n = STABLE;
                    cnt_n   = CW'(1);
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_n = PERIPH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PERIPH: begin
                if (!locked_s) begin
                    loss    = 1'b1;
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (sw_reset_req) begin
                    state_n = SW_HOLD;
                    cnt_n   = '0;
                end else if (cnt == CW'(PERIPH_TO_CPU_CYCLES - 1)) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    loss    = 1'b1;
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (sw_reset_req) begin
                    state_n = SW_HOLD;
                    cnt_n   = '0;
                end
            end
            SW_HOLD: begin
                if (!locked_s) begin
                    loss    = 1'b1;
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == CW'(SW_HOLD_CYCLES - 1)) begin
                    state_n = PERIPH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            periph_resetn <= 1'b0;
            soc_resetn    <= 1'b0;
            ready         <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            periph_resetn <= (state_n == PERIPH) || (state_n == RUN);
            soc_resetn    <= (state_n == RUN);
            ready         <= (state_n == RUN);
        end
    end

    // A fresh loss wins over clear_lost, leaving a count of exactly one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else if (loss) begin
            lock_lost <= 1'b1;
            if (clear_lost) begin
                loss_count <= LOSS_CNT_WIDTH'(1);
            end else if (!(&loss_count)) begin
                loss_count <= loss_count + LOSS_CNT_WIDTH'(1);
            end
        end else if (clear_lost) begin
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed, table-driven bench: each record holds inputs for N edges and the
// output bundle expected after every one of those edges.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       clear_lost = 1'b0;
    logic       periph_resetn, soc_resetn, ready, lock_lost;
    logic [1:0] loss_count;
    logic       done = 1'b0;

    pll_reset_sequencer #(
        .SYNC_STAGES          (2),
        .LOCK_STABLE_CYCLES   (16),
        .PERIPH_TO_CPU_CYCLES (4),
        .SW_HOLD_CYCLES       (8),
        .LOSS_CNT_WIDTH       (2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pll_locked    (pll_locked),
        .sw_reset_req  (sw_reset_req),
        .clear_lost    (clear_lost),
        .periph_resetn (periph_resetn),
        .soc_resetn    (soc_resetn),
        .ready         (ready),
        .lock_lost     (lock_lost),
        .loss_count    (loss_count)
    );

    always #5 clk = ~clk;

    // exp = {periph_resetn, soc_resetn, ready, lock_lost, loss_count[1:0]}
    typedef struct {
        int         n;
        logic       rn;
        logic       pl;
        logic       sw;
        logic       cl;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input int n, input logic rn, input logic pl, input logic sw,
                       input logic cl, input logic p, input logic s, input logic r,
                       input logic l, input logic [1:0] c);
        vec_t v;
        v.n = n; v.rn = rn; v.pl = pl; v.sw = sw; v.cl = cl;
        v.exp = {p, s, r, l, c};
        vecs.push_back(v);
    endtask

    // From WAIT_LOCK with cleared synchroniser: edge 1 is the first sample of lock.
    task automatic relock(input logic l, input logic [1:0] c);
        add(17, 1, 1, 0, 0, 0, 0, 0, l, c);
        add(4,  1, 1, 0, 0, 1, 0, 0, l, c);
        add(1,  1, 1, 0, 0, 1, 1, 1, l, c);
    endtask

    // From RUN: lock drops, seen by the FSM on the third edge.
    task automatic loss_from_run(input logic lb, input logic [1:0] cb, input logic [1:0] ca);
        add(2, 1, 0, 0, 0, 1, 1, 1, lb, cb);
        add(1, 1, 0, 0, 0, 0, 0, 0, 1, ca);
        add(2, 1, 0, 0, 0, 0, 0, 0, 1, ca);
    endtask

    initial begin
        #200000;
        if (!done) begin
            errors++;
            $display("FAIL: timeout waiting for stimulus to complete");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        // power-up: reset held with lock already high, outputs must stay low
        add(3, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0);
        relock(0, 2'd0);
        add(3, 1, 1, 0, 0, 1, 1, 1, 0, 2'd0);
        // loss in RUN, then four more losses saturating at 3
        loss_from_run(0, 2'd0, 2'd1); relock(1, 2'd1);
        loss_from_run(1, 2'd1, 2'd2); relock(1, 2'd2);
        loss_from_run(1, 2'd2, 2'd3); relock(1, 2'd3);
        loss_from_run(1, 2'd3, 2'd3); relock(1, 2'd3);
        loss_from_run(1, 2'd3, 2'd3); relock(1, 2'd3);
        // software reset pulse in RUN
        add(1, 1, 1, 1, 0, 0, 0, 0, 1, 2'd3);
        add(7, 1, 1, 0, 0, 0, 0, 0, 1, 2'd3);
        add(4, 1, 1, 0, 0, 1, 0, 0, 1, 2'd3);
        add(1, 1, 1, 0, 0, 1, 1, 1, 1, 2'd3);
        // second request during hold must not extend it
        add(1, 1, 1, 1, 0, 0, 0, 0, 1, 2'd3);
        add(2, 1, 1, 0, 0, 0, 0, 0, 1, 2'd3);
        add(1, 1, 1, 1, 0, 0, 0, 0, 1, 2'd3);
        add(4, 1, 1, 0, 0, 0, 0, 0, 1, 2'd3);
        add(4, 1, 1, 0, 0, 1, 0, 0, 1, 2'd3);
        add(1, 1, 1, 0, 0, 1, 1, 1, 1, 2'd3);
        // loss + sw request + clear on the same edge
        add(2, 1, 0, 0, 0, 1, 1, 1, 1, 2'd3);
        add(1, 1, 0, 1, 1, 0, 0, 0, 1, 2'd1);
        add(2, 1, 0, 0, 0, 0, 0, 0, 1, 2'd1);
        // resetn pulsed low mid-PERIPH
        add(17, 1, 1, 0, 0, 0, 0, 0, 1, 2'd1);
        add(2,  1, 1, 0, 0, 1, 0, 0, 1, 2'd1);
        add(2,  0, 1, 0, 0, 0, 0, 0, 0, 2'd0);
        relock(0, 2'd0);
        // lock glitch during STABLE: not counted, full period restarts
        loss_from_run(0, 2'd0, 2'd1);
        add(12, 1, 1, 0, 0, 0, 0, 0, 1, 2'd1);
        add(3,  1, 0, 0, 0, 0, 0, 0, 1, 2'd1);
        relock(1, 2'd1);
        // clear_lost alone: flags clear, sequencing unaffected
        add(1, 1, 1, 0, 1, 1, 1, 1, 0, 2'd0);
        add(2, 1, 1, 0, 0, 1, 1, 1, 0, 2'd0);

        resetn       = 1'b0;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        clear_lost   = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (periph_resetn !== 1'b0 || soc_resetn !== 1'b0 || ready !== 1'b0 ||
            lock_lost !== 1'b0 || loss_count !== 2'd0) begin
            errors++;
            $display("FAIL reset state: p=%b s=%b r=%b l=%b cnt=%b",
                     periph_resetn, soc_resetn, ready, lock_lost, loss_count);
        end

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                logic [5:0] got;
                resetn       = vecs[i].rn;
                pll_locked   = vecs[i].pl;
                sw_reset_req = vecs[i].sw;
                clear_lost   = vecs[i].cl;
                @(posedge clk);
                #1;
                got = {periph_resetn, soc_resetn, ready, lock_lost, loss_count};
                checks++;
                if (got !== vecs[i].exp) begin
                    errors++;
                    $display("FAIL vec%0d edge%0d: got {p,s,r,l,cnt}=%b required %b",
                             i, k, got, vecs[i].exp);
                end
            end
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
